// File: rtl/mul_wb.sv
// Multiplier writeback stage: tracks issued multiplier ops, queues Rn results in a
// 2-entry FIFO toward the register file, and keeps ASTAT/sticky flags. Define
// MUL_WB_STKY_EN to build the sticky multiplier-overflow flag (stky_mos).
module mul_wb #(
    parameter int RF_DATASIZE = 16,
    parameter int RF_ADDRSIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ps_mul_en,
    input  logic                   ps_mul_otreg,
    input  logic [RF_ADDRSIZE-1:0] ps_mul_dstadd,
    input  logic [RF_DATASIZE-1:0] mul_xb_dt,
    input  logic                   mul_ps_mv,
    input  logic                   mul_ps_mn,
    input  logic                   ps_stall,
    input  logic                   ps_astat_clr,
    input  logic                   ps_stky_clr,
    output logic                   mulwb_rf_wen,
    output logic [RF_ADDRSIZE-1:0] mulwb_rf_add,
    output logic [RF_DATASIZE-1:0] mulwb_rf_dt,
    output logic                   astat_mv,
    output logic                   astat_mn,
    output logic                   stky_mos,
    output logic                   mulwb_ovf
);

    localparam int ENT_W = RF_ADDRSIZE + RF_DATASIZE;

    logic                   iss_vld;
    logic                   iss_otreg;
    logic [RF_ADDRSIZE-1:0] iss_dst;

    logic [ENT_W-1:0]       fifo_mem [2];
    logic [1:0]             count;
    logic                   wr_ptr;
    logic                   rd_ptr;

    logic                   push;
    logic                   push_acc;
    logic                   pop;
    logic                   full;

    // Issue stage: remember where the result of this cycle's issue must go.
    always_ff @(posedge clk) begin
        if (ps_mul_en) begin
            iss_otreg <= ps_mul_otreg;
            iss_dst   <= ps_mul_dstadd;
        end
    end

    // Result stage: iss_vld marks the cycle the multiplier outputs are valid.
    assign full     = (count == 2'd2);
    assign push     = iss_vld && !iss_otreg;
    assign pop      = (count != 2'd0) && !ps_stall;
    // A full queue still accepts a push when the head leaves at the same edge.
    assign push_acc = push && (!full || pop);

    assign mulwb_rf_wen = pop;
    assign {mulwb_rf_add, mulwb_rf_dt} = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_vld     <= 1'b0;
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            mulwb_ovf   <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            iss_vld <= ps_mul_en;
            if (push_acc) begin
                fifo_mem[wr_ptr] <= {iss_dst, mul_xb_dt};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (push && !push_acc)
                mulwb_ovf <= 1'b1;
            case ({push_acc, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A result update takes priority over a software clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            astat_mv <= 1'b0;
            astat_mn <= 1'b0;
        end else if (iss_vld) begin
            astat_mv <= mul_ps_mv;
            astat_mn <= mul_ps_mn;
        end else if (ps_astat_clr) begin
            astat_mv <= 1'b0;
            astat_mn <= 1'b0;
        end
    end

`ifdef MUL_WB_STKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stky_mos <= 1'b0;
        else if (iss_vld && mul_ps_mv)
            stky_mos <= 1'b1;
        else if (ps_stky_clr)
            stky_mos <= 1'b0;
    end
`else
    logic unused_stky_clr;
    assign unused_stky_clr = ps_stky_clr;
    assign stky_mos        = 1'b0;
`endif

endmodule

// File: tb/tb_mul_wb.sv
// Directed self-checking bench for mul_wb: latency, queue full/overflow,
// flags, sticky overflow and asynchronous reset behaviour.
module tb_mul_wb;

    localparam int DW = 16;
    localparam int AW = 4;
`ifdef MUL_WB_STKY_EN
    localparam bit STKY = 1'b1;
`else
    localparam bit STKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ps_mul_en, ps_mul_otreg;
    logic [AW-1:0] ps_mul_dstadd;
    logic [DW-1:0] mul_xb_dt;
    logic          mul_ps_mv, mul_ps_mn;
    logic          ps_stall, ps_astat_clr, ps_stky_clr;
    logic          mulwb_rf_wen;
    logic [AW-1:0] mulwb_rf_add;
    logic [DW-1:0] mulwb_rf_dt;
    logic          astat_mv, astat_mn, stky_mos, mulwb_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_wb #(.RF_DATASIZE(DW), .RF_ADDRSIZE(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg), .ps_mul_dstadd(ps_mul_dstadd),
        .mul_xb_dt(mul_xb_dt), .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn),
        .ps_stall(ps_stall), .ps_astat_clr(ps_astat_clr), .ps_stky_clr(ps_stky_clr),
        .mulwb_rf_wen(mulwb_rf_wen), .mulwb_rf_add(mulwb_rf_add), .mulwb_rf_dt(mulwb_rf_dt),
        .astat_mv(astat_mv), .astat_mn(astat_mn), .stky_mos(stky_mos), .mulwb_ovf(mulwb_ovf)
    );

    // Start a new cycle: inputs are changed at the falling edge, held to the next rise.
    task automatic next_cycle();
        @(negedge clk);
        ps_mul_en = 1'b0; ps_mul_otreg = 1'b0; ps_mul_dstadd = '0;
        mul_xb_dt = '0; mul_ps_mv = 1'b0; mul_ps_mn = 1'b0;
        ps_stall = 1'b0; ps_astat_clr = 1'b0; ps_stky_clr = 1'b0;
    endtask

    task automatic issue(input logic otreg, input logic [AW-1:0] dst);
        ps_mul_en = 1'b1; ps_mul_otreg = otreg; ps_mul_dstadd = dst;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_cycle();
        #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected 0", mulwb_rf_wen); end
        n_checks++; if (mulwb_rf_add !== 4'd0) begin n_fail++; $display("FAIL reset_add: got %h expected 0", mulwb_rf_add); end
        n_checks++; if (mulwb_rf_dt !== 16'd0) begin n_fail++; $display("FAIL reset_dt: got %h expected 0", mulwb_rf_dt); end
        n_checks++; if ({astat_mv, astat_mn, stky_mos, mulwb_ovf} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {astat_mv, astat_mn, stky_mos, mulwb_ovf}); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL idle_wen: got %b expected 0", mulwb_rf_wen); end
    endtask

    task automatic test_latency();
        next_cycle(); issue(1'b0, 4'd5); #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL lat_c0_wen: got %b expected 0", mulwb_rf_wen); end
        next_cycle(); mul_xb_dt = 16'h1234; #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL lat_c1_wen: got %b expected 0", mulwb_rf_wen); end
        next_cycle(); #1;
        n_checks++; if (mulwb_rf_wen !== 1'b1) begin n_fail++; $display("FAIL lat_c2_wen: got %b expected 1", mulwb_rf_wen); end
        n_checks++; if (mulwb_rf_add !== 4'd5) begin n_fail++; $display("FAIL lat_c2_add: got %h expected 5", mulwb_rf_add); end
        n_checks++; if (mulwb_rf_dt !== 16'h1234) begin n_fail++; $display("FAIL lat_c2_dt: got %h expected 1234", mulwb_rf_dt); end
        next_cycle(); #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL lat_c3_wen: got %b expected 0", mulwb_rf_wen); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_add [3];
        logic [DW-1:0] exp_dt  [3];
        exp_add[0] = 4'd7; exp_add[1] = 4'd8; exp_add[2] = 4'd9;
        exp_dt[0] = 16'h1111; exp_dt[1] = 16'h2222; exp_dt[2] = 16'h3333;
        next_cycle(); issue(1'b0, exp_add[0]);
        next_cycle(); issue(1'b0, exp_add[1]); mul_xb_dt = exp_dt[0];
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i < 1) issue(1'b0, exp_add[2]);
            if (i < 2) mul_xb_dt = exp_dt[i + 1];
            #1;
            n_checks++; if (mulwb_rf_wen !== 1'b1) begin n_fail++; $display("FAIL b2b_wen[%0d]: got %b expected 1", i, mulwb_rf_wen); end
            n_checks++; if (mulwb_rf_add !== exp_add[i]) begin n_fail++; $display("FAIL b2b_add[%0d]: got %h expected %h", i, mulwb_rf_add, exp_add[i]); end
            n_checks++; if (mulwb_rf_dt !== exp_dt[i]) begin n_fail++; $display("FAIL b2b_dt[%0d]: got %h expected %h", i, mulwb_rf_dt, exp_dt[i]); end
        end
        next_cycle(); #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL b2b_end_wen: got %b expected 0", mulwb_rf_wen); end
    endtask

    task automatic test_flags();
        next_cycle(); issue(1'b1, 4'd4);
        next_cycle(); mul_ps_mv = 1'b1; mul_ps_mn = 1'b1; #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL mr_c1_wen: got %b expected 0", mulwb_rf_wen); end
        next_cycle(); ps_astat_clr = 1'b1; #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL mr_c2_wen: got %b expected 0", mulwb_rf_wen); end
        n_checks++; if ({astat_mv, astat_mn} !== 2'b11) begin n_fail++; $display("FAIL mr_astat: got %b expected 11", {astat_mv, astat_mn}); end
        n_checks++; if (stky_mos !== STKY) begin n_fail++; $display("FAIL mr_stky: got %b expected %b", stky_mos, STKY); end
        next_cycle(); issue(1'b0, 4'd6); #1;
        n_checks++; if ({astat_mv, astat_mn} !== 2'b00) begin n_fail++; $display("FAIL astat_clr: got %b expected 00", {astat_mv, astat_mn}); end
        next_cycle(); mul_xb_dt = 16'hBEEF; mul_ps_mn = 1'b1; ps_astat_clr = 1'b1;
        next_cycle(); #1;
        n_checks++; if ({astat_mv, astat_mn} !== 2'b01) begin n_fail++; $display("FAIL astat_win: got %b expected 01", {astat_mv, astat_mn}); end
        n_checks++; if ({mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt} !== {1'b1, 4'd6, 16'hBEEF}) begin n_fail++; $display("FAIL flags_wr: got %b/%h/%h expected 1/6/beef", mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt); end
        next_cycle(); #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL flags_end_wen: got %b expected 0", mulwb_rf_wen); end
    endtask

    task automatic test_sticky();
        next_cycle(); ps_stky_clr = 1'b1;
        next_cycle(); issue(1'b1, 4'd0); #1;
        n_checks++; if (stky_mos !== 1'b0) begin n_fail++; $display("FAIL stky_clr0: got %b expected 0", stky_mos); end
        next_cycle(); mul_ps_mv = 1'b1; ps_stky_clr = 1'b1;
        next_cycle(); ps_stky_clr = 1'b1; #1;
        n_checks++; if (stky_mos !== STKY) begin n_fail++; $display("FAIL stky_set_wins: got %b expected %b", stky_mos, STKY); end
        next_cycle(); #1;
        n_checks++; if (stky_mos !== 1'b0) begin n_fail++; $display("FAIL stky_clr1: got %b expected 0", stky_mos); end
    endtask

    task automatic test_full_push_pop();
        next_cycle(); issue(1'b0, 4'd10);
        next_cycle(); issue(1'b0, 4'd11); mul_xb_dt = 16'h00A0; ps_stall = 1'b1;
        next_cycle(); mul_xb_dt = 16'h00B1; ps_stall = 1'b1;
        next_cycle(); issue(1'b0, 4'd12); ps_stall = 1'b1; #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL full_stall_wen: got %b expected 0", mulwb_rf_wen); end
        next_cycle(); mul_xb_dt = 16'h00C2; #1;
        n_checks++; if ({mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt} !== {1'b1, 4'd10, 16'h00A0}) begin n_fail++; $display("FAIL full_pop0: got %b/%h/%h expected 1/a/00a0", mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt); end
        next_cycle(); #1;
        n_checks++; if ({mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt} !== {1'b1, 4'd11, 16'h00B1}) begin n_fail++; $display("FAIL full_pop1: got %b/%h/%h expected 1/b/00b1", mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt); end
        n_checks++; if (mulwb_ovf !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b expected 0", mulwb_ovf); end
        next_cycle(); #1;
        n_checks++; if ({mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt} !== {1'b1, 4'd12, 16'h00C2}) begin n_fail++; $display("FAIL full_pop2: got %b/%h/%h expected 1/c/00c2", mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt); end
        next_cycle(); #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL full_end_wen: got %b expected 0", mulwb_rf_wen); end
    endtask

    task automatic test_overflow();
        next_cycle(); issue(1'b0, 4'd1);
        next_cycle(); issue(1'b0, 4'd2); mul_xb_dt = 16'hA001; ps_stall = 1'b1;
        next_cycle(); issue(1'b0, 4'd3); mul_xb_dt = 16'hA002; ps_stall = 1'b1; #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL ovf_c2_wen: got %b expected 0", mulwb_rf_wen); end
        next_cycle(); mul_xb_dt = 16'hA003; ps_stall = 1'b1; #1;
        n_checks++; if (mulwb_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", mulwb_ovf); end
        next_cycle(); ps_stall = 1'b1; #1;
        n_checks++; if (mulwb_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", mulwb_ovf); end
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL ovf_c4_wen: got %b expected 0", mulwb_rf_wen); end
        next_cycle(); ps_stall = 1'b1;
        next_cycle(); #1;
        n_checks++; if ({mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt} !== {1'b1, 4'd1, 16'hA001}) begin n_fail++; $display("FAIL ovf_wr1: got %b/%h/%h expected 1/1/a001", mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt); end
        next_cycle(); #1;
        n_checks++; if ({mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt} !== {1'b1, 4'd2, 16'hA002}) begin n_fail++; $display("FAIL ovf_wr2: got %b/%h/%h expected 1/2/a002", mulwb_rf_wen, mulwb_rf_add, mulwb_rf_dt); end
        next_cycle(); #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got %b expected 0", mulwb_rf_wen); end
        n_checks++; if (mulwb_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", mulwb_ovf); end
    endtask

    task automatic test_reset_mid();
        int writes;
        next_cycle(); issue(1'b0, 4'd13);
        next_cycle(); issue(1'b0, 4'd14); mul_xb_dt = 16'h5555; mul_ps_mv = 1'b1; mul_ps_mn = 1'b1; ps_stall = 1'b1;
        next_cycle(); mul_xb_dt = 16'h6666; ps_stall = 1'b1;
        next_cycle(); issue(1'b0, 4'd15); ps_stall = 1'b1; #1;
        rst_n = 1'b0; ps_stall = 1'b0; #1;
        n_checks++; if (mulwb_rf_wen !== 1'b0) begin n_fail++; $display("FAIL rmid_wen: got %b expected 0", mulwb_rf_wen); end
        n_checks++; if ({mulwb_rf_add, mulwb_rf_dt} !== 20'd0) begin n_fail++; $display("FAIL rmid_data: got %h/%h expected 0/0", mulwb_rf_add, mulwb_rf_dt); end
        n_checks++; if ({astat_mv, astat_mn, stky_mos, mulwb_ovf} !== 4'b0000) begin n_fail++; $display("FAIL rmid_flags: got %b expected 0000", {astat_mv, astat_mn, stky_mos, mulwb_ovf}); end
        next_cycle(); mul_xb_dt = 16'h7777;
        next_cycle(); rst_n = 1'b1; mul_xb_dt = 16'h7777;
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle(); #1;
            if (mulwb_rf_wen === 1'b1) writes++;
        end
        n_checks++; if (writes !== 0) begin n_fail++; $display("FAIL rmid_writes: got %0d expected 0", writes); end
    endtask

    initial begin
        rst_n = 1'b0;
        ps_mul_en = 1'b0; ps_mul_otreg = 1'b0; ps_mul_dstadd = '0;
        mul_xb_dt = '0; mul_ps_mv = 1'b0; mul_ps_mn = 1'b0;
        ps_stall = 1'b0; ps_astat_clr = 1'b0; ps_stky_clr = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_flags();
        test_sticky();
        test_full_push_pop();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
